// File: rtl/qqspi_target.sv
// qqspi_target
//   Serial memory target for a single/quad SPI-style link that runs on the
//   same clock as its initiator. The target decodes a command byte (single
//   write 0x02, single read 0x03, quad write 0x38, quad read 0xEB), takes a
//   24-bit byte address and then streams bytes to or from a 32-bit word
//   memory until it is deselected.
//
// Parameters
//   CEN_NPOL  : 1 -> cen active-high, 0 -> cen active-low
//   CHIP_ID   : cs value this target answers to
//
// Ports
//   clk, resetn          : clock and synchronous active-low reset
//   cen, sclk, cs        : chip enable, serial clock, chip select (from initiator)
//   sio*_i / sio*_o      : serial data lanes in / out
//   sio_oe               : per-lane output enable (bit i -> sio i)
//   mem_addr             : word address into the backing memory
//   mem_rdata            : combinational read data for mem_addr
//   mem_wdata, mem_wmask : write data (byte replicated) and one-hot byte mask
//   mem_we               : single-clk write strobe per completed byte
//   active               : a valid command is in progress
module qqspi_target #(
  parameter logic       CEN_NPOL = 1'b0,
  parameter logic [1:0] CHIP_ID  = 2'b00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cen,
  input  logic        sclk,
  input  logic [1:0]  cs,
  input  logic        sio0_si_mosi_i,
  input  logic        sio1_so_miso_i,
  input  logic        sio2_i,
  input  logic        sio3_i,
  output logic        sio0_si_mosi_o,
  output logic        sio1_so_miso_o,
  output logic        sio2_o,
  output logic        sio3_o,
  output logic [3:0]  sio_oe,
  output logic [21:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_we,
  output logic        active
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RD_LOAD,
    RD_DATA,
    WR_DATA,
    IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic        sclk_q;
  logic        armed_q, armed_d;
  logic [23:0] ptr_q, ptr_d;
  logic [22:0] sr_q, sr_d;
  logic [7:0]  out_sr_q, out_sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        quad_q, quad_d;
  logic        wr_q, wr_d;

  logic        selected;
  logic        rise;
  logic [3:0]  nib;
  logic [7:0]  cmd_byte;
  logic [23:0] addr_next;
  logic [7:0]  wr_byte;
  logic [7:0]  rd_byte;
  logic        byte_last;

  assign selected  = ((cen ^ CEN_NPOL) == 1'b0) && (cs == CHIP_ID);
  assign rise      = sclk & ~sclk_q;
  assign nib       = {sio3_i, sio2_i, sio1_so_miso_i, sio0_si_mosi_i};
  assign cmd_byte  = {sr_q[6:0], sio0_si_mosi_i};
  assign addr_next = quad_q ? {sr_q[19:0], nib} : {sr_q[22:0], sio0_si_mosi_i};
  assign wr_byte   = quad_q ? {sr_q[3:0], nib} : {sr_q[6:0], sio0_si_mosi_i};
  assign byte_last = quad_q ? (cnt_q == 5'd1) : (cnt_q == 5'd7);
  assign mem_addr  = ptr_q[23:2];

  // Byte lane 0 is the most significant byte of the memory word.
  always_comb begin
    rd_byte = mem_rdata[31:24];
    case (ptr_q[1:0])
      2'd0:    rd_byte = mem_rdata[31:24];
      2'd1:    rd_byte = mem_rdata[23:16];
      2'd2:    rd_byte = mem_rdata[15:8];
      default: rd_byte = mem_rdata[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      sclk_q   <= 1'b0;
      armed_q  <= 1'b0;
      ptr_q    <= '0;
      sr_q     <= '0;
      out_sr_q <= '0;
      cnt_q    <= '0;
      quad_q   <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sclk_q   <= sclk;
      armed_q  <= armed_d;
      ptr_q    <= ptr_d;
      sr_q     <= sr_d;
      out_sr_q <= out_sr_d;
      cnt_q    <= cnt_d;
      quad_q   <= quad_d;
      wr_q     <= wr_d;
    end
  end

  // armed_q only becomes set once a deselect has been seen, so a target that
  // comes out of reset while already selected ignores that stale transfer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sr_d      = sr_q;
    out_sr_d  = out_sr_q;
    cnt_d     = cnt_q;
    quad_d    = quad_q;
    wr_d      = wr_q;
    armed_d   = armed_q | ~selected;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_wmask = '0;

    if (!selected) begin
      state_d = IDLE;
      cnt_d   = '0;
      sr_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q) begin
            state_d = CMD;
            cnt_d   = '0;
            sr_d    = '0;
          end
        end

        CMD: begin
          if (rise) begin
            sr_d  = {sr_q[21:0], sio0_si_mosi_i};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              sr_d  = '0;
              case (cmd_byte)
                8'h02: begin state_d = ADDR; wr_d = 1'b1; quad_d = 1'b0; end
                8'h03: begin state_d = ADDR; wr_d = 1'b0; quad_d = 1'b0; end
                8'h38: begin state_d = ADDR; wr_d = 1'b1; quad_d = 1'b1; end
                8'hEB: begin state_d = ADDR; wr_d = 1'b0; quad_d = 1'b1; end
                default: state_d = IGNORE;
              endcase
            end
          end
        end

        ADDR: begin
          if (rise) begin
            sr_d  = addr_next[22:0];
            cnt_d = cnt_q + 5'd1;
            if (quad_q ? (cnt_q == 5'd5) : (cnt_q == 5'd23)) begin
              ptr_d = addr_next;
              cnt_d = '0;
              sr_d  = '0;
              if (wr_q)        state_d = WR_DATA;
              else if (quad_q) state_d = DUMMY;
              else             state_d = RD_LOAD;
            end
          end
        end

        DUMMY: begin
          if (rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd5) begin
              out_sr_d = rd_byte;
              ptr_d    = ptr_q + 24'd1;
              cnt_d    = '0;
              state_d  = RD_DATA;
            end
          end
        end

        RD_LOAD: begin
          out_sr_d = rd_byte;
          ptr_d    = ptr_q + 24'd1;
          cnt_d    = '0;
          state_d  = RD_DATA;
        end

        // The completing rise reloads the shifter in the same clk so the
        // next byte's MSB is already on the lane before the following rise.
        RD_DATA: begin
          if (rise) begin
            cnt_d    = cnt_q + 5'd1;
            out_sr_d = quad_q ? {out_sr_q[3:0], 4'h0} : {out_sr_q[6:0], 1'b0};
            if (byte_last) begin
              cnt_d    = '0;
              out_sr_d = rd_byte;
              ptr_d    = ptr_q + 24'd1;
            end
          end
        end

        WR_DATA: begin
          if (rise) begin
            cnt_d = cnt_q + 5'd1;
            sr_d  = {15'd0, wr_byte};
            if (byte_last) begin
              cnt_d     = '0;
              sr_d      = '0;
              ptr_d     = ptr_q + 24'd1;
              mem_we    = resetn;
              mem_wdata = {4{wr_byte}};
              mem_wmask = 4'b1000 >> ptr_q[1:0];
            end
          end
        end

        IGNORE: begin
          state_d = IGNORE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Lanes are only driven while selected and streaming read data.
  always_comb begin
    sio0_si_mosi_o = 1'b0;
    sio1_so_miso_o = 1'b0;
    sio2_o         = 1'b0;
    sio3_o         = 1'b0;
    sio_oe         = 4'b0000;
    active         = 1'b0;
    if (selected) begin
      if (state_q inside {ADDR, DUMMY, RD_LOAD, RD_DATA, WR_DATA}) begin
        active = 1'b1;
      end
      if (state_q == RD_DATA) begin
        if (quad_q) begin
          {sio3_o, sio2_o, sio1_so_miso_o, sio0_si_mosi_o} = out_sr_q[7:4];
          sio_oe = 4'b1111;
        end else begin
          sio1_so_miso_o = out_sr_q[7];
          sio_oe         = 4'b0010;
        end
      end
    end
  end

endmodule

// File: tb/tb_qqspi_target.sv
// tb_qqspi_target
//   Bench for qqspi_target. Acts as the initiator, keeps a byte-addressed
//   reference memory and predicts every write strobe and every read byte
//   from the command/address/data that it sends.
`timescale 1ns/1ps
module tb_qqspi_target;

  localparam logic [1:0] TARGET_ID = 2'b10;

  logic        clk;
  logic        resetn;
  logic        cen;
  logic        sclk;
  logic [1:0]  cs;
  logic        sio0_si_mosi_i;
  logic        sio1_so_miso_i;
  logic        sio2_i;
  logic        sio3_i;
  logic        sio0_si_mosi_o;
  logic        sio1_so_miso_o;
  logic        sio2_o;
  logic        sio3_o;
  logic [3:0]  sio_oe;
  logic [21:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_we;
  logic        active;

  int          checks = 0;
  int          failures = 0;

  logic [31:0] mem [64];
  logic [7:0]  refByte [256];
  logic [7:0]  txData [8];
  logic [7:0]  rxData [8];
  logic [21:0] wrAddrQ [$];
  logic [31:0] wrDataQ [$];
  logic [3:0]  wrMaskQ [$];

  logic [3:0]  lastOe;
  logic [3:0]  lastLanes;
  logic        lastActive;
  int          oeErrs;
  int          laneErrs;
  logic        anyActive;
  logic        allActive;

  qqspi_target #(
    .CEN_NPOL(1'b0),
    .CHIP_ID (TARGET_ID)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cen           (cen),
    .sclk          (sclk),
    .cs            (cs),
    .sio0_si_mosi_i(sio0_si_mosi_i),
    .sio1_so_miso_i(sio1_so_miso_i),
    .sio2_i        (sio2_i),
    .sio3_i        (sio3_i),
    .sio0_si_mosi_o(sio0_si_mosi_o),
    .sio1_so_miso_o(sio1_so_miso_o),
    .sio2_o        (sio2_o),
    .sio3_o        (sio3_o),
    .sio_oe        (sio_oe),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_we        (mem_we),
    .active        (active)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory aliased on the low six word-address bits.
  assign mem_rdata = mem[mem_addr[5:0]];

  // Write strobes last only until the next posedge, so capture them 1 ns
  // before that edge and log every pulse for later comparison.
  always @(negedge clk) begin
    #4;
    if (mem_we === 1'b1) begin
      wrAddrQ.push_back(mem_addr);
      wrDataQ.push_back(mem_wdata);
      wrMaskQ.push_back(mem_wmask);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Rebuild the DUT-facing word memory from the byte-level reference.
  task automatic syncMem();
    for (int w = 0; w < 64; w++) begin
      mem[w] = {refByte[4*w], refByte[4*w+1], refByte[4*w+2], refByte[4*w+3]};
    end
  endtask

  // One serial clock: present data with sclk low, sample the target's lanes
  // late in the low phase, then raise sclk.
  task automatic spiCycle(input logic [3:0] nib);
    {sio3_i, sio2_i, sio1_so_miso_i, sio0_si_mosi_i} = nib;
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    lastLanes  = {sio3_o, sio2_o, sio1_so_miso_o, sio0_si_mosi_o};
    lastOe     = sio_oe;
    lastActive = active;
    sclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic trackPhase(input logic [3:0] expOe, input logic [3:0] laneMask);
    if (lastOe !== expOe) oeErrs++;
    if ((lastLanes & ~laneMask) !== 4'b0000) laneErrs++;
    anyActive = anyActive | lastActive;
    allActive = allActive & lastActive;
  endtask

  // Full initiator transaction: select, command, address, optional dummy,
  // nBytes of data, extraBits trailing partial-byte clocks, deselect.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] addr,
                               input int nBytes, input int extraBits,
                               input logic [1:0] csVal);
    logic       quad;
    logic       isRd;
    logic [7:0] b;
    quad = (cmd == 8'h38) || (cmd == 8'hEB);
    isRd = (cmd == 8'h03) || (cmd == 8'hEB);
    oeErrs = 0;
    laneErrs = 0;
    anyActive = 1'b0;
    allActive = 1'b1;
    cen = 1'b0;
    cs = csVal;
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 7; i >= 0; i--) spiCycle({3'b000, cmd[i]});
    if (quad) begin
      for (int i = 5; i >= 0; i--) begin
        spiCycle(addr[4*i +: 4]);
        trackPhase(4'b0000, 4'b0000);
      end
    end else begin
      for (int i = 23; i >= 0; i--) begin
        spiCycle({3'b000, addr[i]});
        trackPhase(4'b0000, 4'b0000);
      end
    end
    if (cmd == 8'hEB) begin
      for (int i = 0; i < 6; i++) begin
        spiCycle(4'h0);
        trackPhase(4'b0000, 4'b0000);
      end
    end
    for (int k = 0; k < nBytes; k++) begin
      if (isRd) begin
        b = 8'h00;
        if (quad) begin
          for (int i = 0; i < 2; i++) begin
            spiCycle(4'h0);
            trackPhase(4'b1111, 4'b1111);
            b = {b[3:0], lastLanes};
          end
        end else begin
          for (int i = 0; i < 8; i++) begin
            spiCycle(4'h0);
            trackPhase(4'b0010, 4'b0010);
            b = {b[6:0], lastLanes[1]};
          end
        end
        rxData[k] = b;
      end else begin
        b = txData[k];
        if (quad) begin
          for (int i = 1; i >= 0; i--) begin
            spiCycle(b[4*i +: 4]);
            trackPhase(4'b0000, 4'b0000);
          end
        end else begin
          for (int i = 7; i >= 0; i--) begin
            spiCycle({3'b000, b[i]});
            trackPhase(4'b0000, 4'b0000);
          end
        end
      end
    end
    for (int i = 0; i < extraBits; i++) begin
      spiCycle(quad ? 4'hF : 4'h1);
      trackPhase(4'b0000, 4'b0000);
    end
    cen = 1'b1;
    sclk = 1'b0;
    {sio3_i, sio2_i, sio1_so_miso_i, sio0_si_mosi_i} = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  // Compare one transaction against the reference model and fold any
  // expected writes into the reference memory.
  task automatic checkTxn(input logic [7:0] cmd, input logic [23:0] addr,
                          input int nBytes, input logic respond, input int wrBase,
                          input string tag);
    logic        isWr;
    logic        isRd;
    logic        valid;
    logic [23:0] a;
    int          got;
    isWr  = (cmd == 8'h02) || (cmd == 8'h38);
    isRd  = (cmd == 8'h03) || (cmd == 8'hEB);
    valid = respond && (isWr || isRd);
    checkOutput({tag, ".oe"}, oeErrs, 0);
    checkOutput({tag, ".lanes"}, laneErrs, 0);
    if (valid) checkOutput({tag, ".activeHeld"}, {31'd0, allActive}, 1);
    else       checkOutput({tag, ".activeIdle"}, {31'd0, anyActive}, 0);
    got = wrAddrQ.size() - wrBase;
    checkOutput({tag, ".wrCount"}, got, (valid && isWr) ? nBytes : 0);
    if (valid && isWr) begin
      for (int k = 0; k < nBytes && k < got; k++) begin
        a = addr + 24'(k);
        checkOutput({tag, ".wrAddr"}, {10'd0, wrAddrQ[wrBase+k]}, {10'd0, a[23:2]});
        checkOutput({tag, ".wrMask"}, {28'd0, wrMaskQ[wrBase+k]}, {28'd0, 4'b1000 >> a[1:0]});
        checkOutput({tag, ".wrData"}, wrDataQ[wrBase+k], {4{txData[k]}});
      end
      for (int k = 0; k < nBytes; k++) begin
        a = addr + 24'(k);
        refByte[a[7:0]] = txData[k];
      end
      syncMem();
    end
    if (valid && isRd) begin
      for (int k = 0; k < nBytes; k++) begin
        a = addr + 24'(k);
        checkOutput({tag, ".rdByte"}, {24'd0, rxData[k]}, {24'd0, refByte[a[7:0]]});
      end
    end
  endtask

  initial begin
    int          base;
    logic [7:0]  rc;
    logic [23:0] ra;
    int          rn;

    resetn = 1'b0;
    cen = 1'b1;
    cs = TARGET_ID;
    sclk = 1'b0;
    {sio3_i, sio2_i, sio1_so_miso_i, sio0_si_mosi_i} = 4'h0;
    for (int i = 0; i < 256; i++) refByte[i] = 8'($urandom);
    syncMem();
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("reset.oe", {28'd0, sio_oe}, 0);
    checkOutput("reset.lanes", {28'd0, sio3_o, sio2_o, sio1_so_miso_o, sio0_si_mosi_o}, 0);
    checkOutput("reset.active", {31'd0, active}, 0);
    checkOutput("reset.we", {31'd0, mem_we}, 0);
    checkOutput("reset.addr", {10'd0, mem_addr}, 0);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] stale select across reset");
    resetn = 1'b0;
    cen = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    txData[0] = 8'h5A;
    base = wrAddrQ.size();
    applyStimulus(8'h02, 24'h000040, 1, 0, TARGET_ID);
    checkTxn(8'h02, 24'h000040, 1, 1'b0, base, "stale");

    $display("[TB] single write");
    txData[0] = 8'hA5;
    base = wrAddrQ.size();
    applyStimulus(8'h02, 24'h000003, 1, 0, TARGET_ID);
    checkTxn(8'h02, 24'h000003, 1, 1'b1, base, "sw");
    if (wrAddrQ.size() > base) begin
      checkOutput("sw.addr0", {10'd0, wrAddrQ[base]}, 0);
      checkOutput("sw.mask", {28'd0, wrMaskQ[base]}, 32'h1);
      checkOutput("sw.byte", {24'd0, wrDataQ[base][7:0]}, 32'hA5);
    end

    $display("[TB] quad write word");
    txData[0] = 8'hDE; txData[1] = 8'hAD; txData[2] = 8'hBE; txData[3] = 8'hEF;
    base = wrAddrQ.size();
    applyStimulus(8'h38, 24'h000010, 4, 0, TARGET_ID);
    checkTxn(8'h38, 24'h000010, 4, 1'b1, base, "qw");
    if (wrAddrQ.size() >= base + 4) begin
      checkOutput("qw.addr4", {10'd0, wrAddrQ[base+3]}, 4);
      checkOutput("qw.masks", {16'd0, wrMaskQ[base], wrMaskQ[base+1], wrMaskQ[base+2],
                  wrMaskQ[base+3]}, 32'h8421);
    end

    $display("[TB] single read");
    refByte[0] = 8'h11; refByte[1] = 8'h22; refByte[2] = 8'h33; refByte[3] = 8'h44;
    syncMem();
    base = wrAddrQ.size();
    applyStimulus(8'h03, 24'h000000, 4, 0, TARGET_ID);
    checkTxn(8'h03, 24'h000000, 4, 1'b1, base, "sr");
    checkOutput("sr.word", {rxData[0], rxData[1], rxData[2], rxData[3]}, 32'h11223344);

    $display("[TB] quad read with dummy");
    refByte[4] = 8'hCA; refByte[5] = 8'hFE; refByte[6] = 8'hF0; refByte[7] = 8'h0D;
    syncMem();
    base = wrAddrQ.size();
    applyStimulus(8'hEB, 24'h000004, 4, 0, TARGET_ID);
    checkTxn(8'hEB, 24'h000004, 4, 1'b1, base, "qr");
    checkOutput("qr.word", {rxData[0], rxData[1], rxData[2], rxData[3]}, 32'hCAFEF00D);

    $display("[TB] boundaries");
    base = wrAddrQ.size();
    applyStimulus(8'h03, 24'hFFFFFF, 2, 0, TARGET_ID);
    checkTxn(8'h03, 24'hFFFFFF, 2, 1'b1, base, "wrap");
    txData[0] = 8'h3C; txData[1] = 8'hC3;
    base = wrAddrQ.size();
    applyStimulus(8'h9F, 24'h000123, 2, 0, TARGET_ID);
    checkTxn(8'h9F, 24'h000123, 2, 1'b1, base, "ignore");
    base = wrAddrQ.size();
    applyStimulus(8'h02, 24'h000020, 0, 5, TARGET_ID);
    checkTxn(8'h02, 24'h000020, 0, 1'b1, base, "abort5");
    txData[0] = 8'h96;
    base = wrAddrQ.size();
    applyStimulus(8'h38, 24'h000025, 1, 1, TARGET_ID);
    checkTxn(8'h38, 24'h000025, 1, 1'b1, base, "abortNib");
    txData[0] = 8'h77;
    base = wrAddrQ.size();
    applyStimulus(8'h02, 24'h000030, 1, 0, 2'b01);
    checkTxn(8'h02, 24'h000030, 1, 1'b0, base, "otherCs");

    $display("[TB] randomized transactions");
    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 3))
        0:       rc = 8'h02;
        1:       rc = 8'h03;
        2:       rc = 8'h38;
        default: rc = 8'hEB;
      endcase
      ra = 24'($urandom);
      rn = int'($urandom_range(1, 5));
      for (int k = 0; k < 8; k++) txData[k] = 8'($urandom);
      base = wrAddrQ.size();
      applyStimulus(rc, ra, rn, 0, TARGET_ID);
      checkTxn(rc, ra, rn, 1'b1, base, "rand");
    end

    $display("[TB] reset during read data");
    cen = 1'b0;
    cs = TARGET_ID;
    repeat (2) @(negedge clk);
    for (int i = 7; i >= 0; i--) spiCycle({3'b000, rc[i] & 1'b0 | (8'hEB >> i) & 1'b1});
    for (int i = 5; i >= 0; i--) spiCycle((i == 0) ? 4'h8 : 4'h0);
    for (int i = 0; i < 6; i++) spiCycle(4'h0);
    spiCycle(4'h0);
    checkOutput("rst.preOe", {28'd0, lastOe}, 32'hF);
    base = wrAddrQ.size();
    sclk = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("rst.oe", {28'd0, sio_oe}, 0);
    checkOutput("rst.lanes", {28'd0, sio3_o, sio2_o, sio1_so_miso_o, sio0_si_mosi_o}, 0);
    checkOutput("rst.active", {31'd0, active}, 0);
    checkOutput("rst.we", {31'd0, mem_we}, 0);
    resetn = 1'b1;
    cen = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst.noWrite", wrAddrQ.size() - base, 0);
    base = wrAddrQ.size();
    applyStimulus(8'h03, 24'h000008, 2, 0, TARGET_ID);
    checkTxn(8'h03, 24'h000008, 2, 1'b1, base, "recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qqspi_target.md
QQSPI_TARGET -- requirements
Module: qqspi_target

Interface
REQ-001 SHALL have parameter CEN_NPOL, default 1'b0: when 1, cen is active-high; when 0, active-low.
REQ-002 SHALL have parameter CHIP_ID, default 2'b00: cs value this target responds to.
REQ-003 SHALL have port clk  in  1  single clock, shared with the initiator.
REQ-004 SHALL have port resetn  in  1  synchronous active-low reset.
REQ-005 SHALL have ports cen in 1 chip enable, sclk in 1 serial clock, and cs in 2 chip select, all from the initiator.
REQ-006 SHALL have ports sio0_si_mosi_i, sio1_so_miso_i, sio2_i and sio3_i, each in 1, serial data in.
REQ-007 SHALL have ports sio0_si_mosi_o, sio1_so_miso_o, sio2_o and sio3_o, each out 1, serial data out.
REQ-008 SHALL have port sio_oe  out  4  per-lane output enable, bit i for sio i.
REQ-009 SHALL have ports mem_addr out 22 (word address), mem_rdata in 32 (read data, combinational on mem_addr), mem_wdata out 32, mem_wmask out 4 and mem_we out 1.
REQ-010 SHALL have port active  out  1  high while a valid command is in progress.

Function
REQ-011 SHALL sample all inputs directly in clk (no synchronizers); rise = sclk & ~sclk_q, where sclk_q is sclk registered once.
REQ-012 SHALL treat selected = (cen ^ CEN_NPOL)==0 && cs==CHIP_ID; while not selected, it SHALL go to IDLE on the next clk, sio_oe=0, active=0, bit counter=0, and discard partial bytes.
REQ-013 States: IDLE, CMD, ADDR, DUMMY, RD_LOAD, RD_DATA, WR_DATA, IGNORE; IDLE->CMD when selected.
REQ-014 CMD SHALL shift 8 bits from sio0, MSB first, one bit per rise.
REQ-015 On the 8th rise, CMD SHALL decode: 0x02 single write, 0x03 single read, 0x38 quad write, 0xEB quad read; any other value -> IGNORE.
REQ-016 IGNORE SHALL keep sio_oe=0 and active=0 until deselected.
REQ-017 ADDR SHALL shift a 24-bit byte address MSB first: 1 bit/rise on sio0 for 0x02/0x03 (24 rises), 4 bits/rise {sio3..sio0} for 0x38/0xEB (6 rises).
REQ-018 At the last address rise, ADDR SHALL load ptr[23:0] with the address and go to WR_DATA (writes), RD_LOAD (0x03) or DUMMY (0xEB).
REQ-019 DUMMY SHALL count 6 rises with sio_oe=0; on the 6th rise it SHALL perform the byte load (REQ-022) and go to RD_DATA.
REQ-020 RD_LOAD SHALL perform the byte load on the clk after entry, independent of sclk, then go to RD_DATA.
REQ-021 mem_addr SHALL equal ptr[23:2] at all times, except while mem_we is high, when it is the address of the byte being written.
REQ-022 Byte lane k=ptr[1:0] SHALL map to bits [31-8k:24-8k].
REQ-023 Byte load: out_sr[7:0] <= lane ptr[1:0] of mem_rdata; ptr <= ptr+1, wrapping 0xFFFFFF->0x000000.
REQ-024 RD_DATA single mode SHALL drive sio1_so_miso_o=out_sr[7], sio_oe=4'b0010, and shift out_sr left by 1 per rise.
REQ-025 RD_DATA quad mode SHALL drive {sio3..sio0}_o=out_sr[7:4], sio_oe=4'b1111, and shift out_sr left by 4 per rise.
REQ-026 In RD_DATA, on the rise completing a byte (8 single / 2 quad), it SHALL perform the byte load in that same clk, so the next byte's MSB is driven the following cycle.
REQ-027 Undriven output lanes SHALL be 0.
REQ-028 WR_DATA SHALL shift in bits on sio0 (single) or nibbles on {sio3..sio0} (quad), MSB first, with sio_oe=0.
REQ-029 On the rise completing a byte, WR_DATA SHALL combinationally drive, for that clk only: mem_we=1, mem_addr=ptr[23:2], mem_wdata = byte replicated in all 4 lanes, mem_wmask one-hot with bit 3-ptr[1:0] set; ptr SHALL increment with wrap.
REQ-030 Streaming SHALL continue byte-by-byte until deselect: single/half/word writes produce 1/2/4 mem_we pulses.
REQ-031 A partial byte at deselect SHALL NOT be written.
REQ-032 mem_we SHALL be 0 in every state other than WR_DATA byte completion.
REQ-033 active SHALL be 1 from the CMD decode of a valid command until deselect.

Reset
REQ-034 While resetn=0 at a clk edge, it SHALL set: state=IDLE, sclk_q=0, ptr=0, out_sr=0, bit counter=0, sio_oe=0, all sio*_o=0, mem_we=0, active=0.
REQ-035 Reset mid-transfer SHALL abort without a mem_we pulse.
REQ-036 After reset deassertion, it SHALL respond only to a fresh select: if already selected, it waits for deselect then reselect.

Verification
REQ-037 Single write: cmd 0x02, addr 0x000003, data 0xA5 -> one mem_we pulse, mem_addr=0, mem_wmask=4'b0001, mem_wdata[7:0]=0xA5.
REQ-038 Quad write word: cmd 0x38, addr 0x000010, data 0xDEADBEEF -> 4 pulses at mem_addr=4, masks 1000/0100/0010/0001, bytes DE/AD/BE/EF.
REQ-039 Single read: mem word 0=0x11223344, cmd 0x03, addr 0, 32 data clocks -> sio1 stream returns 0x11223344, sio_oe=4'b0010.
REQ-040 Quad read with dummy: word 1=0xCAFEF00D, cmd 0xEB, addr 0x000004, 6 dummy clocks -> sio_oe=0 during dummy, then 0xCAFEF00D on 8 quad clocks.
REQ-041 Boundaries: read at 0xFFFFFF for 2 bytes wraps ptr to 0; cmd 0x9F -> IGNORE with sio_oe=0 and no mem_we; deselect after 5 write bits -> no mem_we; cs!=CHIP_ID -> no response.
REQ-042 Reset with resetn=0 during RD_DATA -> next cycle all outputs 0, state IDLE.
